// File: rtl/decim_ctrl.sv
// Frame sequencer and decimation scheduler for the I/Q path.
// Keeps every R-th valid sample and forwards it via valid/ready.
module decim_ctrl #(
  parameter int DATA_W  = 32,
  parameter int DECIM_W = 8,
  parameter int CNT_W   = 16
) (
  input  logic              fast_clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [DECIM_W-1:0] cfg_decim,
  input  logic [CNT_W-1:0]  cfg_frame_len,
  input  logic              din_valid,
  input  logic [DATA_W-1:0] din_re_Ff,
  input  logic [DATA_W-1:0] din_im_Ff,
  output logic              busy,
  output logic              done,
  output logic              overrun,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [DATA_W-1:0] dout_re_Fs,
  output logic [DATA_W-1:0] dout_im_Fs,
  output logic [CNT_W-1:0]  dout_idx
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0]   CNT_ONE = 1;
  localparam logic [DECIM_W-1:0] PH_ONE  = 1;

  state_t state, state_nxt;

  logic [DECIM_W-1:0] ratio;
  logic [DECIM_W-1:0] phase;
  logic [CNT_W-1:0]   len;
  logic [CNT_W-1:0]   in_cnt;
  logic [CNT_W-1:0]   out_idx;

  logic start_ok;
  logic take;
  logic kept;
  logic last;
  logic load;
  logic drop;

  // Qualify the per-edge events; abort masks samples and start.
  always_comb begin
    start_ok = (state == S_IDLE) && start && !abort;
    take     = (state == S_RUN) && din_valid && !abort;
    kept     = take && (phase == '0);
    last     = take && ((in_cnt + CNT_ONE) == len);
    load     = kept && (!dout_valid || dout_ready);
    drop     = kept && dout_valid && !dout_ready;
  end

  // State register.
  always_ff @(posedge fast_clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; an empty frame completes without running.
  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            if (cfg_frame_len == '0) state_nxt = S_DONE;
            else                     state_nxt = S_RUN;
          end
        end
        S_RUN: begin
          if (last) state_nxt = S_DONE;
        end
        S_DONE: state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);

  // Latch the frame setup and advance the sample counters.
  always_ff @(posedge fast_clk or posedge reset) begin
    if (reset) begin
      ratio   <= '0;
      len     <= '0;
      in_cnt  <= '0;
      phase   <= '0;
      out_idx <= '0;
    end else if (start_ok) begin
      ratio   <= (cfg_decim == '0) ? PH_ONE : cfg_decim;
      len     <= cfg_frame_len;
      in_cnt  <= '0;
      phase   <= '0;
      out_idx <= '0;
    end else if (take) begin
      in_cnt <= in_cnt + CNT_ONE;
      if (phase == ratio - PH_ONE) phase <= '0;
      else                         phase <= phase + PH_ONE;
      if (kept) out_idx <= out_idx + CNT_ONE;
    end
  end

  // Output register; a stalled output drops new samples.
  always_ff @(posedge fast_clk or posedge reset) begin
    if (reset) begin
      overrun    <= 1'b0;
      dout_valid <= 1'b0;
      dout_re_Fs <= '0;
      dout_im_Fs <= '0;
      dout_idx   <= '0;
    end else begin
      if (start_ok)  overrun <= 1'b0;
      else if (drop) overrun <= 1'b1;
      if (load) begin
        dout_valid <= 1'b1;
        dout_re_Fs <= din_re_Ff;
        dout_im_Fs <= din_im_Ff;
        dout_idx   <= out_idx;
      end else if (dout_ready) begin
        dout_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_decim_ctrl.sv
// Directed bench for decim_ctrl.
// Checks decimation, stalls, abort, empty frames and reset.
module tb_decim_ctrl;

  logic        fast_clk = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic [7:0]  cfg_decim;
  logic [15:0] cfg_frame_len;
  logic        din_valid;
  logic [31:0] din_re_Ff;
  logic [31:0] din_im_Ff;
  logic        busy;
  logic        done;
  logic        overrun;
  logic        dout_valid;
  logic        dout_ready;
  logic [31:0] dout_re_Fs;
  logic [31:0] dout_im_Fs;
  logic [15:0] dout_idx;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  logic [31:0] q_re[$];
  logic [31:0] q_im[$];
  logic [15:0] q_idx[$];

  always #5 fast_clk = ~fast_clk;

  decim_ctrl dut (
    .fast_clk      (fast_clk),
    .reset         (reset),
    .start         (start),
    .abort         (abort),
    .cfg_decim     (cfg_decim),
    .cfg_frame_len (cfg_frame_len),
    .din_valid     (din_valid),
    .din_re_Ff     (din_re_Ff),
    .din_im_Ff     (din_im_Ff),
    .busy          (busy),
    .done          (done),
    .overrun       (overrun),
    .dout_valid    (dout_valid),
    .dout_ready    (dout_ready),
    .dout_re_Fs    (dout_re_Fs),
    .dout_im_Fs    (dout_im_Fs),
    .dout_idx      (dout_idx)
  );

  // Record accepted outputs and done pulses mid-cycle.
  always @(negedge fast_clk) begin
    if (dout_valid && dout_ready) begin
      q_re.push_back(dout_re_Fs);
      q_im.push_back(dout_im_Fs);
      q_idx.push_back(dout_idx);
    end
    if (done) done_cnt++;
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge fast_clk);
    #1;
  endtask

  task automatic clr();
    q_re.delete();
    q_im.delete();
    q_idx.delete();
    done_cnt = 0;
  endtask

  task automatic go(input logic [7:0] r,
                    input logic [15:0] l);
    cfg_decim     = r;
    cfg_frame_len = l;
    start         = 1'b1;
    step();
    start         = 1'b0;
  endtask

  task automatic feed(input logic [31:0] v);
    din_valid = 1'b1;
    din_re_Ff = v;
    din_im_Ff = v;
    step();
    din_valid = 1'b0;
  endtask

  // Expected outputs form an arithmetic ramp.
  task automatic exp_ramp(input string tag, input int n,
                          input int base, input int stride);
    chk({tag, "_cnt"}, 64'(q_re.size()), 64'(n));
    for (int k = 0; k < n && k < q_re.size(); k++) begin
      chk({tag, "_re"}, 64'(q_re[k]), 64'(base + stride * k));
      chk({tag, "_im"}, 64'(q_im[k]), 64'(base + stride * k));
      chk({tag, "_idx"}, 64'(q_idx[k]), 64'(k));
    end
  endtask

  initial begin
    reset         = 1'b1;
    start         = 1'b0;
    abort         = 1'b0;
    cfg_decim     = '0;
    cfg_frame_len = '0;
    din_valid     = 1'b0;
    din_re_Ff     = '0;
    din_im_Ff     = '0;
    dout_ready    = 1'b1;
    step();
    step();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_ovr", 64'(overrun), 64'd0);
    chk("rst_vld", 64'(dout_valid), 64'd0);
    chk("rst_re", 64'(dout_re_Fs), 64'd0);
    chk("rst_idx", 64'(dout_idx), 64'd0);
    reset = 1'b0;
    step();

    // R=7, L=80 ramp.
    clr();
    go(8'd7, 16'd80);
    chk("r7_busy", 64'(busy), 64'd1);
    for (int i = 0; i < 79; i++) feed(32'(i));
    chk("r7_nodone", 64'(done), 64'd0);
    feed(32'd79);
    chk("r7_done", 64'(done), 64'd1);
    chk("r7_busy0", 64'(busy), 64'd0);
    step();
    chk("r7_done0", 64'(done), 64'd0);
    step();
    step();
    exp_ramp("r7", 12, 0, 7);
    chk("r7_dcnt", 64'(done_cnt), 64'd1);

    // R=0 behaves as R=1.
    clr();
    go(8'd0, 16'd5);
    for (int i = 0; i < 5; i++) feed(32'(10 + i));
    chk("r0_done", 64'(done), 64'd1);
    step();
    step();
    exp_ramp("r0", 5, 10, 1);
    chk("r0_dcnt", 64'(done_cnt), 64'd1);

    // R=2 with gaps between valid samples.
    clr();
    go(8'd2, 16'd8);
    for (int i = 0; i < 8; i++) begin
      feed(32'(i));
      din_re_Ff = 32'd99;
      din_im_Ff = 32'd99;
      step();
    end
    step();
    exp_ramp("gap", 4, 0, 2);
    chk("gap_dcnt", 64'(done_cnt), 64'd1);

    // R=1 with the output stalled for three samples.
    clr();
    dout_ready = 1'b0;
    go(8'd1, 16'd6);
    feed(32'd20);
    feed(32'd21);
    feed(32'd22);
    chk("stl_vld", 64'(dout_valid), 64'd1);
    chk("stl_re", 64'(dout_re_Fs), 64'd20);
    chk("stl_idx", 64'(dout_idx), 64'd0);
    chk("stl_ovr", 64'(overrun), 64'd1);
    dout_ready = 1'b1;
    feed(32'd23);
    feed(32'd24);
    feed(32'd25);
    chk("stl_dn", 64'(done), 64'd1);
    chk("stl_dnv", 64'(dout_valid), 64'd1);
    step();
    step();
    chk("stl_cnt", 64'(q_re.size()), 64'd4);
    if (q_re.size() == 4) begin
      chk("stl_q0", 64'(q_re[0]), 64'd20);
      chk("stl_i0", 64'(q_idx[0]), 64'd0);
      chk("stl_q1", 64'(q_re[1]), 64'd23);
      chk("stl_i1", 64'(q_idx[1]), 64'd3);
      chk("stl_q3", 64'(q_re[3]), 64'd25);
      chk("stl_i3", 64'(q_idx[3]), 64'd5);
    end
    chk("stl_ovr2", 64'(overrun), 64'd1);

    // Abort after 30 of 80 samples.
    clr();
    go(8'd7, 16'd80);
    chk("ab_ovr0", 64'(overrun), 64'd0);
    for (int i = 0; i < 30; i++) feed(32'(i));
    abort     = 1'b1;
    din_valid = 1'b1;
    step();
    abort     = 1'b0;
    din_valid = 1'b0;
    chk("ab_busy", 64'(busy), 64'd0);
    step();
    step();
    chk("ab_dcnt", 64'(done_cnt), 64'd0);
    exp_ramp("ab", 5, 0, 7);

    // Restart after abort: idx starts again at 0.
    clr();
    go(8'd3, 16'd4);
    for (int i = 0; i < 4; i++) feed(32'(100 + i));
    step();
    step();
    exp_ramp("rs", 2, 100, 3);

    // Empty frame.
    clr();
    go(8'd4, 16'd0);
    chk("l0_done", 64'(done), 64'd1);
    chk("l0_vld", 64'(dout_valid), 64'd0);
    step();
    chk("l0_done0", 64'(done), 64'd0);
    chk("l0_qn", 64'(q_re.size()), 64'd0);

    // Asynchronous reset mid-frame.
    go(8'd1, 16'd10);
    dout_ready = 1'b0;
    feed(32'd55);
    feed(32'd56);
    chk("ar_pre", 64'(busy), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_busy", 64'(busy), 64'd0);
    chk("ar_vld", 64'(dout_valid), 64'd0);
    chk("ar_ovr", 64'(overrun), 64'd0);
    chk("ar_re", 64'(dout_re_Fs), 64'd0);
    chk("ar_im", 64'(dout_im_Fs), 64'd0);
    chk("ar_idx", 64'(dout_idx), 64'd0);
    step();
    reset      = 1'b0;
    dout_ready = 1'b1;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
